// File: rtl/alu_sequencer_pkg.sv
// Shared types and encodings for the PIC16C5x ALU sequencer: ALU function codes,
// opcode patterns, phase encodings and the decode classes used by the sequencer.
package alu_sequencer_pkg;

  localparam int ALU_FUNC_WIDTH = 4;
  localparam int ALU_DATA_WIDTH = 8;

  typedef enum logic [ALU_FUNC_WIDTH-1:0] {
    ALU_IDLE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_IOR  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_COM  = 4'd6,
    ALU_DEC  = 4'd7,
    ALU_INC  = 4'd8,
    ALU_MOV  = 4'd9,
    ALU_RLF  = 4'd10,
    ALU_RRF  = 4'd11,
    ALU_SWAP = 4'd12,
    ALU_BCF  = 4'd13,
    ALU_BSF  = 4'd14
  } alu_func_e;

  // Byte-oriented file ops, matched on inst[11:6]
  localparam logic [5:0] OP_ADDWF  = 6'b000111;
  localparam logic [5:0] OP_SUBWF  = 6'b000010;
  localparam logic [5:0] OP_ANDWF  = 6'b000101;
  localparam logic [5:0] OP_IORWF  = 6'b000100;
  localparam logic [5:0] OP_XORWF  = 6'b000110;
  localparam logic [5:0] OP_COMF   = 6'b001001;
  localparam logic [5:0] OP_DECF   = 6'b000011;
  localparam logic [5:0] OP_DECFSZ = 6'b001011;
  localparam logic [5:0] OP_INCF   = 6'b001010;
  localparam logic [5:0] OP_INCFSZ = 6'b001111;
  localparam logic [5:0] OP_MOVF   = 6'b001000;
  localparam logic [5:0] OP_RLF    = 6'b001101;
  localparam logic [5:0] OP_RRF    = 6'b001100;
  localparam logic [5:0] OP_SWAPF  = 6'b001110;

  // Bit and literal ops, matched on inst[11:8]
  localparam logic [3:0] OP_BCF   = 4'b0100;
  localparam logic [3:0] OP_BSF   = 4'b0101;
  localparam logic [3:0] OP_BTFSC = 4'b0110;
  localparam logic [3:0] OP_BTFSS = 4'b0111;
  localparam logic [3:0] OP_ANDLW = 4'b1110;
  localparam logic [3:0] OP_IORLW = 4'b1101;
  localparam logic [3:0] OP_XORLW = 4'b1111;

  localparam logic [1:0] PH_Q1 = 2'd0;
  localparam logic [1:0] PH_Q2 = 2'd1;
  localparam logic [1:0] PH_Q3 = 2'd2;
  localparam logic [1:0] PH_Q4 = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_Q1, ST_Q2, ST_Q3, ST_Q4} state_e;

  // WR_DEST picks f or W from the d bit; WR_F / WR_W are fixed destinations
  typedef enum logic [1:0] {WR_NONE, WR_DEST, WR_F, WR_W} wr_class_e;

  typedef enum logic [1:0] {SK_NONE, SK_ZERO, SK_BIT_CLR, SK_BIT_SET} skip_class_e;

endpackage

// File: rtl/alu_sequencer_inst_decode.sv
// Combinational instruction decode: maps a 12-bit instruction word to the ALU
// function plus its write, status and skip classes.
module inst_decode
  import alu_sequencer_pkg::*;
(
  input  logic [11:0]               inst,
  output logic [ALU_FUNC_WIDTH-1:0] func,
  output logic [1:0]                wr_class,
  output logic                      status_wr,
  output logic [1:0]                skip_class,
  output logic                      lit_op
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    func       = ALU_IDLE;
    wr_class   = WR_NONE;
    status_wr  = 1'b0;
    skip_class = SK_NONE;
    lit_op     = 1'b0;
    case (inst[11:6])
      OP_ADDWF:  begin func = ALU_ADD;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_SUBWF:  begin func = ALU_SUB;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_ANDWF:  begin func = ALU_AND;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_IORWF:  begin func = ALU_IOR;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_XORWF:  begin func = ALU_XOR;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_COMF:   begin func = ALU_COM;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_DECF:   begin func = ALU_DEC;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_INCF:   begin func = ALU_INC;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_MOVF:   begin func = ALU_MOV;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_RLF:    begin func = ALU_RLF;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_RRF:    begin func = ALU_RRF;  wr_class = WR_DEST; status_wr = 1'b1; end
      OP_SWAPF:  begin func = ALU_SWAP; wr_class = WR_DEST; end
      // Skip-on-zero variants reuse DEC/INC but leave STATUS untouched
      OP_DECFSZ: begin func = ALU_DEC;  wr_class = WR_DEST; skip_class = SK_ZERO; end
      OP_INCFSZ: begin func = ALU_INC;  wr_class = WR_DEST; skip_class = SK_ZERO; end
      default: begin
        case (inst[11:8])
          OP_BCF:   begin func = ALU_BCF; wr_class = WR_F; end
          OP_BSF:   begin func = ALU_BSF; wr_class = WR_F; end
          OP_BTFSC: begin func = ALU_MOV; skip_class = SK_BIT_CLR; end
          OP_BTFSS: begin func = ALU_MOV; skip_class = SK_BIT_SET; end
          OP_ANDLW: begin func = ALU_AND; wr_class = WR_W; status_wr = 1'b1; lit_op = 1'b1; end
          OP_IORLW: begin func = ALU_IOR; wr_class = WR_W; status_wr = 1'b1; lit_op = 1'b1; end
          OP_XORLW: begin func = ALU_XOR; wr_class = WR_W; status_wr = 1'b1; lit_op = 1'b1; end
          default:  ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase (Q1..Q4) PIC16C5x instruction sequencer: latches an instruction,
// drives ALU/file control per phase and squashes the instruction after a taken skip.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [11:0]               inst,
  input  logic                      inst_valid,
  output logic                      inst_ready,
  input  logic [ALU_DATA_WIDTH-1:0] alu_result,
  output logic [ALU_FUNC_WIDTH-1:0] func,
  output logic                      alu_en,
  output logic [2:0]                bit_sel,
  output logic [7:0]                lit,
  output logic [4:0]                f_addr,
  output logic                      f_rd_en,
  output logic                      f_wr_en,
  output logic                      w_wr_en,
  output logic                      status_wr_en,
  output logic                      skip,
  output logic [1:0]                q_phase,
  output logic                      busy
);

  state_e      state, state_next;
  logic [11:0] inst_q;
  logic        skip_pending;
  logic        squash;
  logic [1:0]  wr_class;
  logic        status_wr;
  logic [1:0]  skip_class;
  logic        lit_op;
  logic        accept;
  logic        skip_hit;
  logic        skip_live;
  logic        exec;

  inst_decode u_decode (
    .inst       (inst_q),
    .func       (func),
    .wr_class   (wr_class),
    .status_wr  (status_wr),
    .skip_class (skip_class),
    .lit_op     (lit_op)
  );

  assign inst_ready = (state == ST_IDLE) || (state == ST_Q4);
  assign accept     = inst_valid & inst_ready;
  assign busy       = (state != ST_IDLE);
  assign skip       = squash & busy;
  assign bit_sel    = inst_q[7:5];
  assign lit        = inst_q[7:0];
  assign f_addr     = inst_q[4:0];
  // Enables are gated by rst so an aborted instruction never pulses in the reset cycle
  assign exec       = ~squash & ~rst;
  // A squashed instruction in Q4 consumes the pending skip, so a follower accepted now runs
  assign skip_live  = skip_pending & ~((state == ST_Q4) & squash);

  always_comb begin
    skip_hit = 1'b0;
    case (skip_class)
      SK_ZERO:    skip_hit = (alu_result == '0);
      SK_BIT_CLR: skip_hit = ~alu_result[bit_sel];
      SK_BIT_SET: skip_hit = alu_result[bit_sel];
      default:    skip_hit = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      inst_q       <= '0;
      skip_pending <= 1'b0;
      squash       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        inst_q <= inst;
        squash <= skip_live;
      end
      if ((state == ST_Q3) && !squash)
        skip_pending <= skip_hit;
      else if ((state == ST_Q4) && squash)
        skip_pending <= 1'b0;
    end
  end

  always_comb begin
    state_next   = state;
    q_phase      = PH_Q1;
    f_rd_en      = 1'b0;
    alu_en       = 1'b0;
    f_wr_en      = 1'b0;
    w_wr_en      = 1'b0;
    status_wr_en = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_next = ST_Q1;
      ST_Q1: begin
        state_next = ST_Q2;
        q_phase    = PH_Q1;
      end
      ST_Q2: begin
        state_next = ST_Q3;
        q_phase    = PH_Q2;
        f_rd_en    = exec & (func != ALU_IDLE) & ~lit_op;
      end
      ST_Q3: begin
        state_next = ST_Q4;
        q_phase    = PH_Q3;
        alu_en     = exec & (func != ALU_IDLE);
      end
      ST_Q4: begin
        state_next   = accept ? ST_Q1 : ST_IDLE;
        q_phase      = PH_Q4;
        status_wr_en = exec & status_wr;
        if (exec) begin
          case (wr_class)
            WR_DEST: begin
              f_wr_en = inst_q[5];
              w_wr_en = ~inst_q[5];
            end
            WR_F:    f_wr_en = 1'b1;
            WR_W:    w_wr_en = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table-driven instruction stream with a
// per-instruction scoreboard, plus hand sequences for latency, throughput and reset abort.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [7:0]  alu_result = '0;
  logic [3:0]  func;
  logic        alu_en;
  logic [2:0]  bit_sel;
  logic [7:0]  lit;
  logic [4:0]  f_addr;
  logic        f_rd_en, f_wr_en, w_wr_en, status_wr_en;
  logic        skip;
  logic [1:0]  q_phase;
  logic        busy;

  alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .alu_result   (alu_result),
    .func         (func),
    .alu_en       (alu_en),
    .bit_sel      (bit_sel),
    .lit          (lit),
    .f_addr       (f_addr),
    .f_rd_en      (f_rd_en),
    .f_wr_en      (f_wr_en),
    .w_wr_en      (w_wr_en),
    .status_wr_en (status_wr_en),
    .skip         (skip),
    .q_phase      (q_phase),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] inst;
    logic [7:0]  ar;
    int          gap;
    logic [3:0]  func;
    logic        rd, alu, fwr, wwr, st, sk;
  } vec_t;

  typedef struct {
    logic [11:0] inst;
    logic [3:0]  func;
    logic        rd, alu, fwr, wwr, st, skip;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  int    n_vec = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  bit    skip_model = 1'b0;

  logic [20:0] snap;
  logic        o_rd, o_alu, o_fwr, o_wwr, o_st, misplaced;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [11:0] w, input logic [7:0] ar, input bit push, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!inst_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inst_ready) begin
      check("ready_timeout", {31'd0, inst_ready}, 32'd1);
      return;
    end
    inst       = w;
    alu_result = ar;
    inst_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 inst_valid = 1'b0;
  endtask

  // Bench-side skip model: the instruction after a taken skip is expected fully squashed
  task automatic send_vec(input vec_t v);
    exp_t e;
    repeat (v.gap) @(negedge clk);
    e.inst = v.inst;
    e.func = v.func;
    if (skip_model) begin
      e.rd = 0; e.alu = 0; e.fwr = 0; e.wwr = 0; e.st = 0; e.skip = 1;
      skip_model = 1'b0;
    end else begin
      e.rd = v.rd; e.alu = v.alu; e.fwr = v.fwr; e.wwr = v.wwr; e.st = v.st; e.skip = 0;
      skip_model = v.sk;
    end
    issue(v.inst, v.ar, 1'b1, e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", sb.size(), 32'd0);
  endtask

  // Monitor: gathers one instruction's activity over Q1..Q4 and scores it at Q4
  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) begin
        check("idle_quiet", {26'd0, f_rd_en, alu_en, f_wr_en, w_wr_en, status_wr_en, skip}, 32'd0);
      end else begin
        if (q_phase == 2'd0) begin
          snap = {func, bit_sel, lit, f_addr, skip};
          {o_rd, o_alu, o_fwr, o_wwr, o_st, misplaced} = '0;
        end else if ({func, bit_sel, lit, f_addr, skip} !== snap) begin
          misplaced = 1'b1;
        end
        if (f_rd_en) begin o_rd = 1'b1; if (q_phase != 2'd1) misplaced = 1'b1; end
        if (alu_en)  begin o_alu = 1'b1; if (q_phase != 2'd2) misplaced = 1'b1; end
        if ((f_wr_en | w_wr_en | status_wr_en) && q_phase != 2'd3) misplaced = 1'b1;
        o_fwr = o_fwr | f_wr_en;
        o_wwr = o_wwr | w_wr_en;
        o_st  = o_st | status_wr_en;
        if (q_phase == 2'd3) begin
          if (sb.size() == 0) begin
            check("unexpected_instruction", {20'd0, dut.inst_q}, 32'hFFFFFFFF);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("func@%03h", e.inst), {28'd0, snap[20:17]}, {28'd0, e.func});
            check($sformatf("operands@%03h", e.inst), {16'd0, snap[16:1]},
                  {16'd0, e.inst[7:5], e.inst[7:0], e.inst[4:0]});
            check($sformatf("skip@%03h", e.inst), {31'd0, snap[0]}, {31'd0, e.skip});
            check($sformatf("f_rd_en@%03h", e.inst), {31'd0, o_rd}, {31'd0, e.rd});
            check($sformatf("alu_en@%03h", e.inst), {31'd0, o_alu}, {31'd0, e.alu});
            check($sformatf("f_wr_en@%03h", e.inst), {31'd0, o_fwr}, {31'd0, e.fwr});
            check($sformatf("w_wr_en@%03h", e.inst), {31'd0, o_wwr}, {31'd0, e.wwr});
            check($sformatf("status_wr_en@%03h", e.inst), {31'd0, o_st}, {31'd0, e.st});
            check($sformatf("phase_placement@%03h", e.inst), {31'd0, misplaced}, 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dummy;
    //                inst    ar    gap func      rd alu fwr wwr st sk
    vecs.push_back('{12'h1C5, 8'h00, 0, ALU_ADD,  1, 1,  0,  1,  1, 0});
    vecs.push_back('{12'h1E5, 8'h00, 0, ALU_ADD,  1, 1,  1,  0,  1, 0});
    vecs.push_back('{12'h0A3, 8'h00, 0, ALU_SUB,  1, 1,  1,  0,  1, 0});
    vecs.push_back('{12'h383, 8'h00, 0, ALU_SWAP, 1, 1,  0,  1,  0, 0});
    vecs.push_back('{12'h203, 8'h00, 0, ALU_MOV,  1, 1,  0,  1,  1, 0});
    vecs.push_back('{12'h4E1, 8'h00, 0, ALU_BCF,  1, 1,  1,  0,  0, 0});
    vecs.push_back('{12'hF55, 8'h00, 0, ALU_XOR,  0, 1,  0,  1,  1, 0});
    vecs.push_back('{12'hD0F, 8'h00, 0, ALU_IOR,  0, 1,  0,  1,  1, 0});
    vecs.push_back('{12'h3E7, 8'h01, 0, ALU_INC,  1, 1,  1,  0,  0, 0});
    vecs.push_back('{12'h6A3, 8'h00, 0, ALU_MOV,  1, 1,  0,  0,  0, 1});
    vecs.push_back('{12'hE0F, 8'h00, 0, ALU_AND,  0, 1,  0,  1,  1, 0});
    vecs.push_back('{12'h343, 8'h00, 0, ALU_RLF,  1, 1,  0,  1,  1, 0});
    vecs.push_back('{12'h2E3, 8'h00, 0, ALU_DEC,  1, 1,  1,  0,  0, 1});
    vecs.push_back('{12'h2E3, 8'h00, 8, ALU_DEC,  1, 1,  1,  0,  0, 1});
    vecs.push_back('{12'h2A1, 8'h00, 0, ALU_INC,  1, 1,  1,  0,  1, 0});
    vecs.push_back('{12'h7A3, 8'h20, 0, ALU_MOV,  1, 1,  0,  0,  0, 1});
    vecs.push_back('{12'h263, 8'h00, 0, ALU_COM,  1, 1,  1,  0,  1, 0});
    vecs.push_back('{12'h7A3, 8'h00, 0, ALU_MOV,  1, 1,  0,  0,  0, 0});
    vecs.push_back('{12'h105, 8'h00, 0, ALU_IOR,  1, 1,  0,  1,  1, 0});
    vecs.push_back('{12'h000, 8'h00, 0, ALU_IDLE, 0, 0,  0,  0,  0, 0});
    vecs.push_back('{12'h323, 8'h00, 0, ALU_RRF,  1, 1,  1,  0,  1, 0});
    vecs.push_back('{12'h5E1, 8'h00, 0, ALU_BSF,  1, 1,  1,  0,  0, 0});
    vecs.push_back('{12'h2E3, 8'h05, 0, ALU_DEC,  1, 1,  1,  0,  0, 0});
    vecs.push_back('{12'h3E7, 8'h00, 0, ALU_INC,  1, 1,  1,  0,  0, 1});
    vecs.push_back('{12'h1C5, 8'h00, 0, ALU_ADD,  1, 1,  0,  1,  1, 0});
    vecs.push_back('{12'h165, 8'h00, 0, ALU_AND,  1, 1,  1,  0,  1, 0});
    vecs.push_back('{12'h185, 8'h00, 0, ALU_XOR,  1, 1,  0,  1,  1, 0});
    vecs.push_back('{12'h0C5, 8'h00, 0, ALU_DEC,  1, 1,  0,  1,  1, 0});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_inst_ready", {31'd0, inst_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_q_phase", {30'd0, q_phase}, 32'd0);
    check("reset_func", {28'd0, func}, {28'd0, ALU_IDLE});
    check("reset_enables", {26'd0, f_rd_en, alu_en, f_wr_en, w_wr_en, status_wr_en, skip}, 32'd0);
    mon_en = 1'b1;

    // ADDWF 0x1C5: Q1 one cycle after accept, aluEn at +3, W/STATUS write at +4
    send_vec(vecs[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lat_q_phase%0d", i), {30'd0, q_phase}, i);
      check($sformatf("lat_alu_en%0d", i), {31'd0, alu_en}, {31'd0, i == 2});
      check($sformatf("lat_w_wr%0d", i), {30'd0, w_wr_en, status_wr_en}, (i == 3) ? 32'd3 : 32'd0);
      check($sformatf("lat_f_wr%0d", i), {31'd0, f_wr_en}, 32'd0);
      check($sformatf("lat_ready%0d", i), {31'd0, inst_ready}, {31'd0, i == 3});
    end

    for (int k = 1; k < vecs.size(); k++) send_vec(vecs[k]);

    // BSF held valid: one accept per four cycles, f write each Q4, STATUS never
    begin
      int n = 0;
      exp_t e;
      @(negedge clk);
      while (!inst_ready && n < 20) begin @(negedge clk); n++; end
      e = '{12'h5E1, ALU_BSF, 1, 1, 1, 0, 0, 0};
      inst = 12'h5E1;
      alu_result = 8'h00;
      inst_valid = 1'b1;
      repeat (3) sb.push_back(e);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        check($sformatf("thru_phase%0d", c), {30'd0, q_phase}, c % 4);
        check($sformatf("thru_busy%0d", c), {31'd0, busy}, 32'd1);
        check($sformatf("thru_f_wr%0d", c), {31'd0, f_wr_en}, {31'd0, (c % 4) == 3});
        check($sformatf("thru_status%0d", c), {31'd0, status_wr_en}, 32'd0);
        if (c == 11) inst_valid = 1'b0;
      end
    end

    // Reset clears a pending skip: ADDWF after the reset must execute normally
    send_vec('{12'h2E3, 8'h00, 0, ALU_DEC, 1, 1, 1, 0, 0, 1});
    drain();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    skip_model = 1'b0;
    mon_en = 1'b1;
    send_vec(vecs[0]);
    drain();

    // Reset in Q3 of ADDWF aborts it with no Q4 writes
    mon_en = 1'b0;
    issue(12'h1C5, 8'h00, 1'b0, dummy);
    repeat (3) @(negedge clk);
    check("abort_in_q3", {30'd0, q_phase}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_inst_ready", {31'd0, inst_ready}, 32'd1);
    check("abort_skip", {31'd0, skip}, 32'd0);
    check("abort_func", {28'd0, func}, {28'd0, ALU_IDLE});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_quiet%0d", i),
            {27'd0, f_rd_en, alu_en, f_wr_en, w_wr_en, status_wr_en}, 32'd0);
      @(negedge clk);
    end
    mon_en = 1'b1;
    send_vec('{12'h1E5, 8'h00, 0, ALU_ADD, 1, 1, 1, 0, 1, 0});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
